bcd_conv_scheduler: RTL and testbench
=====================================

BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

Interface
REQ-001 Parameter SETTLE, default 1, cycles each conversion slot is held on the shared converter (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sec  input  6  binary seconds value.
REQ-005 min  input  6  binary minutes value.
REQ-006 hr  input  6  binary hours value.
REQ-007 update  input  1  conversion request, sampled each rising edge.
REQ-008 conv_tens  input  4  tens digit returned by the shared combinational 6-bit hex-to-BCD converter.
REQ-009 conv_units  input  4  units digit returned by the shared converter.
REQ-010 conv_hex  output  6  operand driven to the shared converter.
REQ-011 sec_bcd / min_bcd / hr_bcd  output  8 each  {tens,units} BCD results.
REQ-012 busy  output  1  high when state is not IDLE.
REQ-013 done  output  1  one-cycle pulse: new results valid.
REQ-014 range_err  output  1  last completed set had sec>59, min>59 or hr>23.

Function
REQ-015 The block SHALL time-share one converter among three requesters using FSM states IDLE, SEC, MIN, HR, DONE.
REQ-016 In IDLE with update=1, the block SHALL snapshot sec/min/hr into internal registers and enter SEC on the same edge.
REQ-017 Each of SEC, MIN, HR SHALL last exactly SETTLE cycles, tracked by a slot counter cleared on state entry.
REQ-018 conv_hex SHALL equal the snapshot of sec, min or hr in SEC, MIN or HR respectively, and 6'd0 in IDLE and DONE.
REQ-019 On the last cycle of each slot, the block SHALL capture {conv_tens,conv_units} into a staging register for that requester.
REQ-020 Transitions: SEC->MIN->HR->DONE, each taken on the edge ending the slot.
REQ-021 sec_bcd, min_bcd, hr_bcd and range_err SHALL update together, on the edge entering DONE only; they SHALL hold their values in all other states.
REQ-022 done SHALL be high for exactly the one DONE cycle.
REQ-023 Latency SHALL be 3*SETTLE+1 edges from the edge sampling update to the edge raising done.
REQ-024 range_err SHALL be computed from the snapshot values; out-of-range values SHALL still be converted (0..63 legal to the converter).
REQ-025 update=1 in SEC, MIN, HR or DONE SHALL set a one-deep pending flag; further requests while pending SHALL merge.
REQ-026 Snapshot registers SHALL NOT change while in SEC, MIN or HR.
REQ-027 From DONE, with pending set or update=1, the block SHALL re-snapshot the inputs, clear pending and enter SEC; otherwise it SHALL enter IDLE.
REQ-028 busy SHALL be high in SEC, MIN, HR and DONE.

Reset
REQ-029 With rst_n=0, the block SHALL immediately, without waiting for a clock edge, force: state IDLE, slot counter 0, pending 0, snapshots 0, staging 0, sec_bcd/min_bcd/hr_bcd 8'h00, conv_hex 0, busy 0, done 0, range_err 0.
REQ-030 Reset asserted mid-conversion SHALL discard the conversion; no done pulse SHALL follow.
REQ-031 The first request after rst_n deasserts SHALL be honored on the first rising edge at which update=1.

Verification
REQ-032 SETTLE=1, sec=45, min=7, hr=23, single update pulse -> conv_hex sequence 45,7,23; done 4 edges later; sec_bcd=8'h45, min_bcd=8'h07, hr_bcd=8'h23, range_err=0.
REQ-033 SETTLE=3, inputs change to sec=0, min=0, hr=0 during the MIN slot -> conv_hex holds the original snapshot; done 10 edges after update; outputs reflect the pre-change values.
REQ-034 update pulsed in HR and again in DONE -> exactly one extra conversion starts on the edge leaving DONE with the re-sampled inputs; a second done pulse follows 4 edges later (SETTLE=1).
REQ-035 sec=60, min=59, hr=24 -> sec_bcd=8'h60, hr_bcd=8'h24, range_err=1; a following valid set clears range_err at its done.
REQ-036 rst_n pulsed low during the SEC slot -> all outputs 0 without waiting for a clock edge, busy=0, no done pulse; the next update converts normally.
REQ-037 Sweep of all 64 values on each requester, with a reference model check of every result.

Source files
------------

// File: rtl/bcd_conv_scheduler_if.sv
// Bus between the BCD conversion scheduler and its environment.
//   sec/min/hr/update    : time values and conversion request (into scheduler)
//   conv_tens/conv_units : digits returned by the shared hex-to-BCD converter
//   conv_hex             : operand presented to the shared converter
//   sec_bcd/min_bcd/hr_bcd, busy, done, range_err : scheduler results/status
// slave  = scheduler side, master = environment side.
interface bcd_conv_scheduler_if;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hr;
  logic       update;
  logic [3:0] conv_tens;
  logic [3:0] conv_units;
  logic [5:0] conv_hex;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic       busy;
  logic       done;
  logic       range_err;

  modport slave (
    input  sec, min, hr, update, conv_tens, conv_units,
    output conv_hex, sec_bcd, min_bcd, hr_bcd, busy, done, range_err
  );

  modport master (
    output sec, min, hr, update, conv_tens, conv_units,
    input  conv_hex, sec_bcd, min_bcd, hr_bcd, busy, done, range_err
  );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one external combinational 6-bit hex-to-BCD converter among
// the seconds, minutes and hours requesters.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : scheduler side of bcd_conv_scheduler_if (request inputs,
//            converter operand/digits, BCD results, busy/done/range_err)
// Each slot (SEC, MIN, HR) holds the operand on the converter for SETTLE
// cycles; results are published together on the edge entering DONE.
module bcd_conv_scheduler #(
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_conv_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SEC, MIN, HR, DONE} state_t;

  localparam logic [3:0] SLOT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] slot_cnt;
  logic       pending;
  logic [5:0] snap_sec, snap_min, snap_hr;
  logic [7:0] stage_sec, stage_min, stage_hr;
  logic [5:0] conv_hex;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       busy, done, range_err;

  logic       last_slot;
  logic       start;
  logic [7:0] conv;

  assign last_slot = (slot_cnt == SLOT_LAST);
  assign conv      = {bus.conv_tens, bus.conv_units};
  // A request is taken from IDLE directly, or from DONE when one arrived
  // during the previous conversion (pending) or is present now.
  assign start     = ((state == IDLE) && bus.update) ||
                     ((state == DONE) && (pending || bus.update));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot_cnt  <= 4'd0;
      pending   <= 1'b0;
      snap_sec  <= 6'd0;
      snap_min  <= 6'd0;
      snap_hr   <= 6'd0;
      stage_sec <= 8'h00;
      stage_min <= 8'h00;
      stage_hr  <= 8'h00;
      conv_hex  <= 6'd0;
      sec_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hr_bcd    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        snap_sec <= bus.sec;
        snap_min <= bus.min;
        snap_hr  <= bus.hr;
        conv_hex <= bus.sec;   // operand registered, so it follows state exactly
        slot_cnt <= 4'd0;
        pending  <= 1'b0;
        busy     <= 1'b1;
        state    <= SEC;
      end else begin
        case (state)
          SEC: begin
            if (bus.update) pending <= 1'b1;
            if (last_slot) begin
              stage_sec <= conv;
              conv_hex  <= snap_min;
              slot_cnt  <= 4'd0;
              state     <= MIN;
            end else begin
              slot_cnt <= slot_cnt + 4'd1;
            end
          end
          MIN: begin
            if (bus.update) pending <= 1'b1;
            if (last_slot) begin
              stage_min <= conv;
              conv_hex  <= snap_hr;
              slot_cnt  <= 4'd0;
              state     <= HR;
            end else begin
              slot_cnt <= slot_cnt + 4'd1;
            end
          end
          HR: begin
            if (bus.update) pending <= 1'b1;
            if (last_slot) begin
              // hr digits are captured on this same edge, so publish them
              // straight from the converter rather than from stage_hr.
              stage_hr  <= conv;
              sec_bcd   <= stage_sec;
              min_bcd   <= stage_min;
              hr_bcd    <= conv;
              range_err <= (snap_sec > 6'd59) || (snap_min > 6'd59) ||
                           (snap_hr > 6'd23);
              conv_hex  <= 6'd0;
              slot_cnt  <= 4'd0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              slot_cnt <= slot_cnt + 4'd1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          IDLE: ;
          default: begin
            busy     <= 1'b0;
            conv_hex <= 6'd0;
            slot_cnt <= 4'd0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.conv_hex  = conv_hex;
  assign bus.sec_bcd   = sec_bcd;
  assign bus.min_bcd   = min_bcd;
  assign bus.hr_bcd    = hr_bcd;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.range_err = range_err;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: one instance with SETTLE=1 and one with
// SETTLE=3, each driving its own model of the external hex-to-BCD converter.
// Edge counts below number the edge that samples update as edge 1, so a
// done on edge 3*SETTLE+1 is the expected latency.
module tb_bcd_conv_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bcd_conv_scheduler_if b1();
  bcd_conv_scheduler_if b3();

  bcd_conv_scheduler #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  bcd_conv_scheduler #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // external combinational converter model
  assign b1.conv_tens  = 4'(b1.conv_hex / 6'd10);
  assign b1.conv_units = 4'(b1.conv_hex % 6'd10);
  assign b3.conv_tens  = 4'(b3.conv_hex / 6'd10);
  assign b3.conv_units = 4'(b3.conv_hex % 6'd10);

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0] s, m, h;
    logic [7:0] es, em, eh;
    logic       ee;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  // One conversion on the SETTLE=1 instance; returns done edge number,
  // captured results and the conv_hex values seen on edges 1..3.
  task automatic run_conv(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h,
                          output int lat, output logic [7:0] os, output logic [7:0] om,
                          output logic [7:0] oh, output logic err, output logic [17:0] hs);
    b1.sec = s; b1.min = m; b1.hr = h; b1.update = 1'b1;
    tick();
    b1.update = 1'b0;
    lat = 0; hs = '0; os = '0; om = '0; oh = '0; err = 1'b0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      if (e <= 3) hs = {hs[11:0], b1.conv_hex};
      if (b1.done) begin
        lat = e;
        os = b1.sec_bcd; om = b1.min_bcd; oh = b1.hr_bcd; err = b1.range_err;
      end else begin
        tick();
      end
    end
    tick();
    check("done_width", {30'd0, b1.done, b1.busy}, 32'd0);
  endtask

  vec_t vec[8];

  initial begin
    int lat, n;
    logic [7:0] os, om, oh;
    logic err, seen;
    logic [17:0] hs;

    vec[0] = '{6'd45, 6'd7,  6'd23, 8'h45, 8'h07, 8'h23, 1'b0};
    vec[1] = '{6'd60, 6'd59, 6'd24, 8'h60, 8'h59, 8'h24, 1'b1};
    vec[2] = '{6'd0,  6'd0,  6'd0,  8'h00, 8'h00, 8'h00, 1'b0};
    vec[3] = '{6'd59, 6'd59, 6'd23, 8'h59, 8'h59, 8'h23, 1'b0};
    vec[4] = '{6'd63, 6'd0,  6'd0,  8'h63, 8'h00, 8'h00, 1'b1};
    vec[5] = '{6'd0,  6'd60, 6'd0,  8'h00, 8'h60, 8'h00, 1'b1};
    vec[6] = '{6'd10, 6'd19, 6'd24, 8'h10, 8'h19, 8'h24, 1'b1};
    vec[7] = '{6'd9,  6'd50, 6'd22, 8'h09, 8'h50, 8'h22, 1'b0};

    b1.sec = '0; b1.min = '0; b1.hr = '0; b1.update = 1'b0;
    b3.sec = '0; b3.min = '0; b3.hr = '0; b3.update = 1'b0;

    // reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_state", {b1.sec_bcd, b1.min_bcd, b1.hr_bcd, b1.conv_hex,
                          b1.busy, b1.done}, 32'd0);
    check("reset_err", {31'd0, b1.range_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // table of single conversions, SETTLE=1
    for (int i = 0; i < 8; i++) begin
      run_conv(vec[i].s, vec[i].m, vec[i].h, lat, os, om, oh, err, hs);
      check($sformatf("v%0d_latency", i), lat, 32'd4);
      check($sformatf("v%0d_hexseq", i), {14'd0, hs}, {14'd0, vec[i].s, vec[i].m, vec[i].h});
      check($sformatf("v%0d_bcd", i), {8'd0, os, om, oh}, {8'd0, vec[i].es, vec[i].em, vec[i].eh});
      check($sformatf("v%0d_range_err", i), {31'd0, err}, {31'd0, vec[i].ee});
    end

    // reset pulse in the SEC slot discards the conversion
    b1.sec = 6'd12; b1.min = 6'd34; b1.hr = 6'd5; b1.update = 1'b1;
    tick();
    b1.update = 1'b0;
    check("rst_pre_busy", {31'd0, b1.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out", {b1.sec_bcd, b1.min_bcd, b1.hr_bcd, b1.conv_hex,
                            b1.busy, b1.done}, 32'd0);
    check("rst_async_err", {31'd0, b1.range_err}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin tick(); if (b1.done || b1.busy) seen = 1'b1; end
    check("rst_no_done", {31'd0, seen}, 32'd0);
    run_conv(6'd12, 6'd34, 6'd5, lat, os, om, oh, err, hs);
    check("rst_next_latency", lat, 32'd4);
    check("rst_next_bcd", {7'd0, os, om, oh, err}, {7'd0, 8'h12, 8'h34, 8'h05, 1'b0});

    // requests in HR and DONE merge into a single extra conversion
    b1.sec = 6'd1; b1.min = 6'd2; b1.hr = 6'd3; b1.update = 1'b1;
    tick();
    b1.update = 1'b0;
    tick(); tick();
    check("pend_hr_hex", b1.conv_hex, 32'd3);
    b1.update = 1'b1;
    tick();
    check("pend_first_done", {7'd0, b1.done, b1.sec_bcd, b1.min_bcd, b1.hr_bcd},
          {7'd0, 1'b1, 8'h01, 8'h02, 8'h03});
    b1.sec = 6'd33; b1.min = 6'd44; b1.hr = 6'd11;
    tick();
    b1.update = 1'b0;
    check("pend_resnap_hex", b1.conv_hex, 32'd33);
    n = 1;
    while (!b1.done && n < 20) begin tick(); n++; end
    check("pend_second_latency", n, 32'd4);
    check("pend_second_bcd", {7'd0, b1.sec_bcd, b1.min_bcd, b1.hr_bcd, b1.range_err},
          {7'd0, 8'h33, 8'h44, 8'h11, 1'b0});
    seen = 1'b0;
    repeat (6) begin tick(); if (b1.done) seen = 1'b1; end
    check("pend_only_one", {30'd0, seen, b1.busy}, 32'd0);

    // SETTLE=3: inputs change during MIN slot, snapshot holds
    b3.sec = 6'd45; b3.min = 6'd7; b3.hr = 6'd23; b3.update = 1'b1;
    tick();
    b3.update = 1'b0;
    n = 1;
    check("s3_sec_hex", b3.conv_hex, 32'd45);
    tick(); tick(); tick(); n = 4;
    check("s3_min_hex", b3.conv_hex, 32'd7);
    b3.sec = 6'd0; b3.min = 6'd0; b3.hr = 6'd0;
    tick(); n = 5;
    check("s3_min_hold", b3.conv_hex, 32'd7);
    tick(); tick(); n = 7;
    check("s3_hr_hex", b3.conv_hex, 32'd23);
    while (!b3.done && n < 30) begin tick(); n++; end
    check("s3_latency", n, 32'd10);
    check("s3_bcd", {7'd0, b3.sec_bcd, b3.min_bcd, b3.hr_bcd, b3.range_err},
          {7'd0, 8'h45, 8'h07, 8'h23, 1'b0});
    tick();
    check("s3_done_width", {31'd0, b3.done}, 32'd0);

    // sweep every value through every requester
    for (int v = 0; v < 64; v++) begin
      int s, m, h;
      s = v; m = (v + 21) % 64; h = (v + 42) % 64;
      run_conv(6'(s), 6'(m), 6'(h), lat, os, om, oh, err, hs);
      check($sformatf("sweep%0d", v), {lat[6:0], os, om, oh, err},
            {7'd4, ref_bcd(s), ref_bcd(m), ref_bcd(h), (s > 59) || (m > 59) || (h > 23)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
